// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: run/step controller for a pipelined core.
// Holds the core in reset for RST_CYCLES after system reset. It then runs
// free, or for exactly step_n enabled cycles, and counts the enabled cycles
// in a saturating counter.
//
// Handshake note: start, halt_req and cnt_clr are single-cycle level
// requests. They are sampled on the rising edge and need no acknowledge.
// busy/cpu_en report acceptance from the cycle after start.
module pipe_run_ctrl #(
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned STEP_W     = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step_n,
    input  logic              halt_req,
    input  logic              cnt_clr,
    output logic              cpu_rst,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_IDLE  = 3'd1,
        S_RUN   = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0]       MODE_RUN  = 2'b00;
    localparam logic [1:0]       MODE_STEP = 2'b10;
    localparam logic [7:0]       RST_LAST  = 8'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [7:0]        rst_cnt_q, rst_cnt_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Outputs decode straight from the state register, so they add no latency.
    assign cpu_en      = (state_q == S_RUN) || (state_q == S_STEP);
    assign busy        = cpu_en;
    assign cpu_rst     = (state_q == S_RESET);
    assign done        = (state_q == S_DONE);
    assign cycle_cnt   = cnt_q;
    assign dbg_state_o = state_q;

    // State, hold counter, remaining counter and cycle counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            rst_cnt_q <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic. Halt outranks start in IDLE and outranks completion in STEP.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        rem_d     = rem_q;
        unique case (state_q)
            S_RESET: begin
                if (rst_cnt_q >= RST_LAST) begin
                    state_d   = S_IDLE;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 8'd1;
                end
            end
            S_IDLE: begin
                if (halt_req) begin
                    state_d = S_IDLE;
                end else if (start && (mode == MODE_RUN)) begin
                    state_d = S_RUN;
                end else if (start && (mode == MODE_STEP)) begin
                    if (step_n != '0) begin
                        rem_d   = step_n;
                        state_d = S_STEP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                rem_d = rem_q - 1'b1;
                if (halt_req) begin
                    state_d = S_IDLE;
                end else if (rem_q == {{(STEP_W-1){1'b0}}, 1'b1}) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // Enabled-cycle counter. Clear wins over increment, and the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cpu_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl. Expected status words {cpu_rst,cpu_en,busy,done}
// are queued as stimulus is applied and popped one per clock as the DUT responds.
module tb_pipe_run_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, cnt_clr;
  logic [1:0]  mode;
  logic [15:0] step_n;
  logic        cpu_rst, cpu_en, busy, done;
  logic [31:0] cycle_cnt;
  logic [2:0]  dbg_state;

  // second instance with a 4-bit counter for saturation
  logic        s_start, s_halt;
  logic        s_cpu_rst, s_cpu_en, s_busy, s_done;
  logic [3:0]  s_cnt;
  logic [2:0]  s_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [3:0]  exp_q[$];
  logic [31:0] exp_cnt;

  // ---------------- clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pipe_run_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .step_n(step_n),
    .halt_req(halt_req), .cnt_clr(cnt_clr), .cpu_rst(cpu_rst), .cpu_en(cpu_en),
    .busy(busy), .done(done), .cycle_cnt(cycle_cnt), .dbg_state_o(dbg_state)
  );

  pipe_run_ctrl #(.RST_CYCLES(2), .STEP_W(16), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .mode(mode), .step_n(step_n),
    .halt_req(s_halt), .cnt_clr(cnt_clr), .cpu_rst(s_cpu_rst), .cpu_en(s_cpu_en),
    .busy(s_busy), .done(s_done), .cycle_cnt(s_cnt), .dbg_state_o(s_dbg_state)
  );

  // ---------------- driver / scoreboard tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_n(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // advance one clock, then pop one expected status word and compare
  task automatic step_cmp(input string tag);
    logic [3:0] e;
    tick();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: expected queue empty, got status %0h", tag, {cpu_rst, cpu_en, busy, done});
    end else begin
      e = exp_q.pop_front();
      check(tag, {28'd0, cpu_rst, cpu_en, busy, done}, {28'd0, e});
    end
  endtask

  localparam logic [3:0] ST_RESET = 4'b1000;
  localparam logic [3:0] ST_IDLE  = 4'b0000;
  localparam logic [3:0] ST_EN    = 4'b0110;
  localparam logic [3:0] ST_DONE  = 4'b0001;

  // ---------------- directed sequence
  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; cnt_clr = 1'b0;
    mode = 2'b00; step_n = 16'd0; s_start = 1'b0; s_halt = 1'b0;
    exp_cnt = 32'd0;

    // reset held 3 cycles
    push_n(ST_RESET, 3);
    for (int i = 0; i < 3; i++) step_cmp("rst_hold");
    check("rst_cnt", cycle_cnt, 32'd0);

    // release: cpu_rst stays high for 2 cycles, then IDLE
    rst = 1'b0;
    push_n(ST_RESET, 1);
    push_n(ST_IDLE, 1);
    step_cmp("rst_rel1");
    step_cmp("rst_rel2");
    check("idle_state", {29'd0, dbg_state}, 32'd1);
    check("cnt_after_rst", cycle_cnt, exp_cnt);

    // step-5: five enabled cycles, a done pulse, back to IDLE
    start = 1'b1; mode = 2'b10; step_n = 16'd5;
    push_n(ST_EN, 5); push_n(ST_DONE, 1); push_n(ST_IDLE, 1);
    for (int i = 0; i < 7; i++) begin
      step_cmp("step5");
      start = 1'b0;
    end
    exp_cnt += 5;
    check("step5_cnt", cycle_cnt, exp_cnt);

    // run, halt in the 11th enabled cycle
    start = 1'b1; mode = 2'b00;
    push_n(ST_EN, 11); push_n(ST_IDLE, 1);
    for (int i = 0; i < 12; i++) begin
      step_cmp("run_halt");
      start = 1'b0;
      halt_req = (i == 10);
    end
    halt_req = 1'b0;
    exp_cnt += 11;
    check("run_cnt", cycle_cnt, exp_cnt);

    // step_n = 0: straight to DONE with no enabled cycle
    start = 1'b1; mode = 2'b10; step_n = 16'd0;
    push_n(ST_DONE, 1); push_n(ST_IDLE, 1);
    step_cmp("step0_done");
    start = 1'b0;
    step_cmp("step0_idle");
    check("step0_cnt", cycle_cnt, exp_cnt);

    // reserved modes are ignored
    start = 1'b1; mode = 2'b01; step_n = 16'd4;
    push_n(ST_IDLE, 1);
    step_cmp("mode01");
    mode = 2'b11;
    push_n(ST_IDLE, 1);
    step_cmp("mode11");

    // start with halt in IDLE: halt wins
    mode = 2'b00; halt_req = 1'b1;
    push_n(ST_IDLE, 1);
    step_cmp("start_halt");
    start = 1'b0; halt_req = 1'b0;

    // halt at remaining=1 aborts without done
    start = 1'b1; mode = 2'b10; step_n = 16'd3;
    push_n(ST_EN, 3); push_n(ST_IDLE, 2);
    for (int i = 0; i < 5; i++) begin
      step_cmp("step_abort");
      start = 1'b0;
      halt_req = (i == 2);
    end
    exp_cnt += 3;
    check("abort_cnt", cycle_cnt, exp_cnt);

    // start during RUN is ignored
    start = 1'b1; mode = 2'b00;
    push_n(ST_EN, 2); push_n(ST_IDLE, 1);
    step_cmp("run_ign1");
    mode = 2'b10; step_n = 16'd2;
    step_cmp("run_ign2");
    start = 1'b0; halt_req = 1'b1;
    step_cmp("run_ign3");
    halt_req = 1'b0;
    exp_cnt += 2;
    check("ign_cnt", cycle_cnt, exp_cnt);

    // clear while enabled overrides the increment
    start = 1'b1; mode = 2'b00;
    push_n(ST_EN, 2); push_n(ST_IDLE, 1);
    step_cmp("clr_run1");
    start = 1'b0; cnt_clr = 1'b1;
    step_cmp("clr_run2");
    check("clr_cnt", cycle_cnt, 32'd0);
    cnt_clr = 1'b0; halt_req = 1'b1;
    step_cmp("clr_run3");
    halt_req = 1'b0;
    exp_cnt = 32'd1;
    check("clr_after", cycle_cnt, exp_cnt);

    // reset in the 40th cycle of a 100-step sequence
    start = 1'b1; mode = 2'b10; step_n = 16'd100;
    push_n(ST_EN, 40);
    for (int i = 0; i < 40; i++) begin
      step_cmp("step100");
      start = 1'b0;
    end
    rst = 1'b1;
    push_n(ST_RESET, 1);
    step_cmp("mid_rst");
    check("mid_rst_cnt", cycle_cnt, 32'd0);
    rst = 1'b0;
    push_n(ST_RESET, 1); push_n(ST_IDLE, 2);
    step_cmp("mid_rel1");
    step_cmp("mid_rel2");
    step_cmp("mid_idle");
    exp_cnt = 32'd0;
    check("mid_final_cnt", cycle_cnt, exp_cnt);

    // 4-bit counter: 20 enabled cycles saturate at 15
    mode = 2'b00; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_halt = (i == 19);
      tick();
      if (i == 14) check("sat_reach", {28'd0, s_cnt}, 32'd15);
    end
    s_halt = 1'b0;
    check("sat_hold", {28'd0, s_cnt}, 32'd15);
    check("sat_idle_en", {31'd0, s_cpu_en}, 32'd0);

    // clear from saturation while enabled
    s_start = 1'b1;
    tick();
    s_start = 1'b0; cnt_clr = 1'b1;
    tick();
    check("sat_clr", {28'd0, s_cnt}, 32'd0);
    cnt_clr = 1'b0; s_halt = 1'b1;
    tick();
    s_halt = 1'b0;
    check("sat_post_clr", {28'd0, s_cnt}, 32'd1);
    check("sat_done_low", {31'd0, s_done}, 32'd0);

    check("queue_drained", exp_q.size(), 32'd0);

    // ---------------- final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
